// File: rtl/store_monitor.sv
// Memory-side store observer: logs every store the core issues into a FWFT FIFO
// and produces a registered pass/fail verdict from the result-address convention.
module store_monitor #(
   parameter int          DEPTH        = 8,
   parameter logic [31:0] RESULT_ADDR  = 32'd100,
   parameter logic [31:0] RESULT_VALUE = 32'd25,
   parameter logic [31:0] SCRATCH_ADDR = 32'd96,
   parameter int          TIMEOUT      = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic        log_ready,
   output logic        log_valid,
   output logic [31:0] log_addr,
   output logic [31:0] log_data,
   output logic        overflow,
   output logic [15:0] store_count,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic [1:0]  fail_code
);

   // state   | meaning
   // ST_RUN  | test running, stores sampled, timer counting
   // ST_PASS | correct value written to result address (terminal)
   // ST_FAIL | bad result, illegal address or timeout (terminal)
   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_PASS = 2'd1;
   localparam logic [1:0] ST_FAIL = 2'd2;

   localparam logic [1:0] CODE_NONE    = 2'd0;
   localparam logic [1:0] CODE_BAD_VAL = 2'd1;
   localparam logic [1:0] CODE_BAD_ADR = 2'd2;
   localparam logic [1:0] CODE_TIMEOUT = 2'd3;

   localparam int AW = $clog2(DEPTH);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   logic [1:0]    state, state_nxt;
   logic [1:0]    code_nxt;
   logic [TW-1:0] timer;

   logic [31:0]   mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;

   logic sample, is_result, is_scratch, timer_tc;
   logic empty, full, pop, push_ok, drop;

   assign sample     = (state == ST_RUN) && MemWrite;
   assign is_result  = (DataAdr == RESULT_ADDR);
   assign is_scratch = (DataAdr == SCRATCH_ADDR);
   assign timer_tc   = (TIMEOUT != 0) && (timer == TIMER_LAST);

   always_comb begin
      state_nxt = state;
      code_nxt  = fail_code;
      if (state == ST_RUN) begin
         if (sample && is_result) begin
            if (WriteData == RESULT_VALUE) begin
               state_nxt = ST_PASS;
               code_nxt  = CODE_NONE;
            end else begin
               state_nxt = ST_FAIL;
               code_nxt  = CODE_BAD_VAL;
            end
         end else if (sample && !is_scratch) begin
            state_nxt = ST_FAIL;
            code_nxt  = CODE_BAD_ADR;
         end else if (timer_tc) begin
            // a deciding store on this edge takes priority over the timeout
            state_nxt = ST_FAIL;
            code_nxt  = CODE_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_RUN;
         fail_code   <= CODE_NONE;
         timer       <= '0;
         store_count <= '0;
      end else begin
         state     <= state_nxt;
         fail_code <= code_nxt;
         if (state == ST_RUN && TIMEOUT != 0)
            timer <= timer + TW'(1);
         if (sample && store_count != 16'hFFFF)
            store_count <= store_count + 16'd1;
      end
   end

   assign done = (state != ST_RUN);
   assign pass = (state == ST_PASS);
   assign fail = (state == ST_FAIL);

   // extra pointer bit separates full from empty when the indices match
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = !empty && log_ready;
   assign push_ok = sample && (!full || pop);
   assign drop    = sample && full && !pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_addr[i] <= '0;
            mem_data[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem_addr[wr_ptr[AW-1:0]] <= DataAdr;
            mem_data[wr_ptr[AW-1:0]] <= WriteData;
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
         if (drop)
            overflow <= 1'b1;
      end
   end

   assign log_valid = !empty;
   assign log_addr  = empty ? 32'd0 : mem_addr[rd_ptr[AW-1:0]];
   assign log_data  = empty ? 32'd0 : mem_data[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: a behavioural model with a log scoreboard, a table of
// single-store verdicts, and hand-written timeout/overflow/async-reset sequences.
module tb_store_monitor;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;
   logic        log_ready = 1'b0;
   logic        log_valid;
   logic [31:0] log_addr;
   logic [31:0] log_data;
   logic        overflow;
   logic [15:0] store_count;
   logic        done;
   logic        pass;
   logic        fail;
   logic [1:0]  fail_code;

   store_monitor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .log_ready(log_ready), .log_valid(log_valid),
      .log_addr(log_addr), .log_data(log_data), .overflow(overflow),
      .store_count(store_count), .done(done), .pass(pass), .fail(fail),
      .fail_code(fail_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic        ep;
      logic        ef;
      logic [1:0]  ec;
   } vec_t;

   ent_t sb[$];
   int   m_state;
   int   m_code;
   int   m_count;
   int   m_timer;
   int   m_ovf;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      sb.delete();
      m_state = 0;
      m_code  = 0;
      m_count = 0;
      m_timer = 0;
      m_ovf   = 0;
   endtask

   // Drive one cycle: compare the log head before the edge, advance the model, check after.
   task automatic cycle(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
      ent_t e;
      logic popping;
      MemWrite  = mw;
      DataAdr   = a;
      WriteData = d;
      log_ready = rdy;
      chk("log_valid", 32'(log_valid), 32'(sb.size() > 0));
      if (sb.size() > 0) begin
         chk("log_addr", log_addr, sb[0].a);
         chk("log_data", log_data, sb[0].d);
      end
      popping = rdy && (sb.size() > 0);
      if (popping) void'(sb.pop_front());
      if (m_state == 0) begin
         if (mw) begin
            if (m_count < 65535) m_count++;
            e.a = a;
            e.d = d;
            if (sb.size() < DEPTH) sb.push_back(e);
            else m_ovf = 1;
            if (a == 32'd100) begin
               m_state = (d == 32'd25) ? 1 : 2;
               m_code  = (d == 32'd25) ? 0 : 1;
            end else if (a != 32'd96) begin
               m_state = 2;
               m_code  = 2;
            end
         end
         if (m_state == 0 && m_timer == TIMEOUT - 1) begin
            m_state = 2;
            m_code  = 3;
         end
         m_timer++;
      end
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      chk("done", 32'(done), 32'(m_state != 0));
      chk("pass", 32'(pass), 32'(m_state == 1));
      chk("fail", 32'(fail), 32'(m_state == 2));
      chk("fail_code", 32'(fail_code), 32'(m_code));
      chk("store_count", 32'(store_count), 32'(m_count));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      MemWrite  = 1'b0;
      log_ready = 1'b0;
      DataAdr   = '0;
      WriteData = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_log_valid", 32'(log_valid), 32'd0);
      chk("rst_log_addr", log_addr, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_count", 32'(store_count), 32'd0);
      reset = 1'b1;
      model_clear();
   endtask

   vec_t vt[6];

   initial begin
      vt[0] = '{a: 32'd100, d: 32'd25,  ep: 1'b1, ef: 1'b0, ec: 2'd0};
      vt[1] = '{a: 32'd100, d: 32'd24,  ep: 1'b0, ef: 1'b1, ec: 2'd1};
      vt[2] = '{a: 32'd104, d: 32'd25,  ep: 1'b0, ef: 1'b1, ec: 2'd2};
      vt[3] = '{a: 32'd96,  d: 32'd7,   ep: 1'b0, ef: 1'b0, ec: 2'd0};
      vt[4] = '{a: 32'd97,  d: 32'd25,  ep: 1'b0, ef: 1'b1, ec: 2'd2};
      vt[5] = '{a: 32'd0,   d: 32'd100, ep: 1'b0, ef: 1'b1, ec: 2'd2};
      model_clear();

      // single-store verdicts, then a late (100,25) that must be ignored once decided
      for (int i = 0; i < 6; i++) begin
         do_reset();
         cycle(1'b1, vt[i].a, vt[i].d, 1'b0);
         chk("tbl_pass", 32'(pass), 32'(vt[i].ep));
         chk("tbl_fail", 32'(fail), 32'(vt[i].ef));
         chk("tbl_code", 32'(fail_code), 32'(vt[i].ec));
         cycle(1'b1, 32'd100, 32'd25, 1'b0);
         if (vt[i].ep || vt[i].ef) chk("tbl_frozen_count", 32'(store_count), 32'd1);
         for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0, 32'd0, 1'b1);
      end

      // pass sequence and in-order drain
      do_reset();
      cycle(1'b1, 32'd96, 32'd7, 1'b0);
      cycle(1'b1, 32'd96, 32'd9, 1'b0);
      cycle(1'b1, 32'd100, 32'd25, 1'b0);
      chk("seq_pass", 32'(pass), 32'd1);
      chk("seq_count", 32'(store_count), 32'd3);
      chk("seq_head_addr", log_addr, 32'd96);
      chk("seq_head_data", log_data, 32'd7);
      for (int k = 0; k < 4; k++) cycle(1'b0, 32'd0, 32'd0, 1'b1);
      chk("seq_drained", 32'(log_valid), 32'd0);

      // illegal address leaves exactly one logged entry
      do_reset();
      cycle(1'b1, 32'd104, 32'd25, 1'b0);
      cycle(1'b1, 32'd96, 32'd1, 1'b1);
      chk("ill_one_entry", 32'(log_valid), 32'd0);

      // timeout fires on the 20th edge after release
      do_reset();
      for (int k = 0; k < TIMEOUT - 1; k++) cycle(1'b0, 32'd0, 32'd0, 1'b0);
      chk("to_not_yet", 32'(fail), 32'd0);
      cycle(1'b0, 32'd0, 32'd0, 1'b0);
      chk("to_fail", 32'(fail), 32'd1);
      chk("to_code", 32'(fail_code), 32'd3);

      // deciding store on the timeout edge wins
      do_reset();
      for (int k = 0; k < TIMEOUT - 1; k++) cycle(1'b0, 32'd0, 32'd0, 1'b0);
      cycle(1'b1, 32'd100, 32'd25, 1'b0);
      chk("to_race_pass", 32'(pass), 32'd1);
      chk("to_race_code", 32'(fail_code), 32'd0);

      // overflow: ten stores with consumer stalled
      do_reset();
      for (int k = 0; k < 10; k++) cycle(1'b1, 32'd96, 32'(k), 1'b0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(store_count), 32'd10);
      for (int k = 0; k < DEPTH + 1; k++) cycle(1'b0, 32'd0, 32'd0, 1'b1);

      // full with simultaneous push and pop on the ninth store
      do_reset();
      for (int k = 0; k < 8; k++) cycle(1'b1, 32'd96, 32'(k + 16), 1'b0);
      cycle(1'b1, 32'd96, 32'd24, 1'b1);
      chk("fullpp_no_ovf", 32'(overflow), 32'd0);
      chk("fullpp_count", 32'(store_count), 32'd9);
      for (int k = 0; k < DEPTH + 1; k++) cycle(1'b0, 32'd0, 32'd0, 1'b1);

      // asynchronous reset mid-run clears outputs without a clock edge
      do_reset();
      for (int k = 0; k < 3; k++) cycle(1'b1, 32'd96, 32'(k + 40), 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("async_log_valid", 32'(log_valid), 32'd0);
      chk("async_log_data", log_data, 32'd0);
      chk("async_count", 32'(store_count), 32'd0);
      chk("async_done", 32'(done), 32'd0);
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle(1'b1, 32'd100, 32'd25, 1'b0);
      chk("post_rst_count", 32'(store_count), 32'd1);
      chk("post_rst_pass", 32'(pass), 32'd1);
      cycle(1'b0, 32'd0, 32'd0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
